// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multi-cycle memory responder.
package mc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic SZ_WORD  = 1'b1;
  localparam logic SZ_DWORD = 1'b0;

  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/mc_mem_array.sv
// DEPTH x 64-bit storage with independent 32-bit half write enables and a registered read port.
module mc_mem_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we_lo_i,
  input  logic                     we_hi_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [63:0]              wdata_i,
  output logic [63:0]              rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  // NOTE: storage and its read register have no reset; clearing a RAM costs a
  // mux per bit and is never needed because the responder masks rdata after reset.
  always_ff @(posedge clk) begin
    if (we_lo_i) mem_q[idx_i][31:0]  <= wdata_i[31:0];
    if (we_hi_i) mem_q[idx_i][63:32] <= wdata_i[63:32];
    if (re_i)    rdata_q             <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_mem_responder.sv
// Unified instruction/data memory responder: valid/ready request, WAIT_CYCLES wait states, one-shot response.
// Optional macro MC_MEM_ALIGN_CHECK_EN: flag misaligned accesses on rsp_err instead of forcing alignment.
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic              req_word,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               req_ready_q, busy_q, rsp_valid_q;
  logic               req_we_q, req_word_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [63:0]        req_wdata_q;
  logic               rsp_err_q, rsp_zero_q, rsp_word_q, rsp_half_q;

  logic               misaligned, in_access, sel_hi, do_store, do_load;
  logic               we_lo, we_hi;
  logic [63:0]        arr_wdata, arr_rdata;
  logic               unused_addr_bits;

`ifdef MC_MEM_ALIGN_CHECK_EN
  assign misaligned = (req_word_q == SZ_WORD) ? (req_addr_q[1:0] != 2'b00)
                                              : (req_addr_q[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // Array is only touched during ACCESS, so a reset that drops the state to IDLE
  // mid-access also kills the pending write.
  assign in_access = (state_q == ACCESS);
  assign sel_hi    = req_addr_q[2];
  assign do_store  = in_access & req_we_q & ~misaligned;
  assign do_load   = in_access & ~req_we_q & ~misaligned;
  assign we_lo     = do_store & ((req_word_q == SZ_DWORD) | ~sel_hi);
  assign we_hi     = do_store & ((req_word_q == SZ_DWORD) | sel_hi);
  assign arr_wdata = (req_word_q == SZ_WORD) ? {2{req_wdata_q[31:0]}} : req_wdata_q;

  assign unused_addr_bits = ^{req_addr_q[ADDR_W-1:IDX_W+3], req_addr_q[1:0]};

  mc_mem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .we_lo_i (we_lo),
    .we_hi_i (we_hi),
    .re_i    (do_load),
    .idx_i   (req_addr_q[IDX_W+2:3]),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // NOTE: every state register uses non-blocking assignment so all of them
  // update together on the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b1;
      rsp_word_q  <= 1'b0;
      rsp_half_q  <= 1'b0;
      req_we_q    <= 1'b0;
      req_word_q  <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_we_q    <= req_we;
            req_word_q  <= req_word;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            cnt_q       <= WAIT_INIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= ACCESS;
        end
        ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= misaligned;
          rsp_zero_q  <= req_we_q | misaligned;
          rsp_word_q  <= req_word_q;
          rsp_half_q  <= sel_hi;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Formatting flags only change on the ACCESS exit edge, so rsp_rdata holds until the next RESP.
  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    rsp_rdata = arr_rdata;
    if (rsp_zero_q)
      rsp_rdata = '0;
    else if (rsp_word_q == SZ_WORD)
      rsp_rdata = {32'h0, rsp_half_q ? arr_rdata[63:32] : arr_rdata[31:0]};
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Self-checking bench for mc_mem_responder: directed scenarios plus randomized traffic against a memory model.
module tb_mc_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 1024;
  localparam int LAT   = W + 2;

`ifdef MC_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic        req_word = 1'b0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_rdata;

  int errors = 0;
  int checks = 0;

  logic [63:0] mdl [DEPTH];

  mc_mem_responder #(.ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory: doubleword array indexed modulo DEPTH, word halves chosen by address/4 parity.
  function automatic void model(input bit we, input bit word, input logic [31:0] addr,
                                input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int idx;
    bit upper, mis;
    idx   = int'((addr / 8) % DEPTH);
    upper = ((addr / 4) % 2) == 1;
    mis   = ALIGN && (word ? (addr % 4) != 0 : (addr % 8) != 0);
    rd = '0;
    er = mis;
    if (mis) return;
    if (we) begin
      if (!word)      mdl[idx] = wd;
      else if (upper) mdl[idx][63:32] = wd[31:0];
      else            mdl[idx][31:0] = wd[31:0];
    end else if (!word) begin
      rd = mdl[idx];
    end else begin
      rd = upper ? {32'h0, mdl[idx][63:32]} : {32'h0, mdl[idx][31:0]};
    end
  endfunction

  // Called at a negedge; returns at the negedge of the IDLE cycle following RESP.
  task automatic do_req(input bit we, input bit word, input logic [31:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_word = word; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    lat = -1; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      if (rsp_valid === 1'b1) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL one_shot: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
  endtask

  task automatic test_dword_round_trip;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model(1'b1, 1'b0, 32'h40, 64'h1122334455667788, erd, eer);
    do_req(1'b1, 1'b0, 32'h40, 64'h1122334455667788, rd, er, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL sd_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL sd_rdata: got %h expected 0", rd); end
    do_req(1'b0, 1'b0, 32'h40, 64'h0, rd, er, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL ld_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL ld_rdata: got %h expected 1122334455667788", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL ld_err: got %b expected 0", er); end
  endtask

  task automatic test_word_half;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model(1'b1, 1'b1, 32'h44, 64'hCAFEF00DDEADBEEF, erd, eer);
    do_req(1'b1, 1'b1, 32'h44, 64'hCAFEF00DDEADBEEF, rd, er, lat);
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL sw_rdata: got %h expected 0", rd); end
    do_req(1'b0, 1'b0, 32'h40, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'hDEADBEEF55667788) begin errors++; $display("FAIL half_ld: got %h expected deadbeef55667788", rd); end
    do_req(1'b0, 1'b1, 32'h40, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0000000055667788) begin errors++; $display("FAIL half_lw: got %h expected 0000000055667788", rd); end
    do_req(1'b0, 1'b1, 32'h44, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h00000000DEADBEEF) begin errors++; $display("FAIL half_lw_hi: got %h expected 00000000deadbeef", rd); end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] rd, last; logic er; int lat, cnt, first;
    req_valid = 1'b1; req_we = 1'b0; req_word = 1'b0; req_addr = 32'h40; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL wait_busy: busy=%b ready=%b expected 1/0", busy, req_ready); end
    req_we = 1'b1; req_wdata = 64'h0;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0; first = -1; last = '0;
    for (int k = 2; k < 14; k++) begin
      if (rsp_valid === 1'b1) begin
        cnt++; last = rsp_rdata;
        if (first < 0) first = k;
      end
      @(negedge clk);
    end
    checks++; if (cnt != 1) begin errors++; $display("FAIL ignore_count: got %0d responses expected 1", cnt); end
    checks++; if (first != LAT) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", first, LAT); end
    checks++; if (last !== 64'hDEADBEEF55667788) begin errors++; $display("FAIL ignore_rdata: got %h expected deadbeef55667788", last); end
    do_req(1'b0, 1'b0, 32'h40, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'hDEADBEEF55667788) begin errors++; $display("FAIL ignore_mem: got %h expected deadbeef55667788", rd); end
  endtask

  task automatic test_wrap;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model(1'b1, 1'b0, 32'h2000, 64'hA5, erd, eer);
    do_req(1'b1, 1'b0, 32'h2000, 64'hA5, rd, er, lat);
    model(1'b0, 1'b0, 32'h0, 64'h0, erd, eer);
    do_req(1'b0, 1'b0, 32'h0, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'hA5 || erd !== 64'hA5) begin errors++; $display("FAIL alias_ld: got %h expected a5", rd); end
    model(1'b1, 1'b0, 32'h1FF8, 64'h0123456789ABCDEF, erd, eer);
    do_req(1'b1, 1'b0, 32'h1FF8, 64'h0123456789ABCDEF, rd, er, lat);
    model(1'b0, 1'b0, 32'h3FF8, 64'h0, erd, eer);
    do_req(1'b0, 1'b0, 32'h3FF8, 64'h0, rd, er, lat);
    checks++; if (rd !== erd) begin errors++; $display("FAIL last_dword_alias: got %h expected %h", rd, erd); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd, erd; logic er, eer; int lat, cnt;
    model(1'b1, 1'b0, 32'h80, 64'h0BADF00D12345678, erd, eer);
    do_req(1'b1, 1'b0, 32'h80, 64'h0BADF00D12345678, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_word = 1'b0; req_addr = 32'h80; req_wdata = 64'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (W) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: busy=%b ready=%b valid=%b expected 0/1/0", busy, req_ready, rsp_valid);
    end
    checks++; if (rsp_rdata !== 64'h0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", rsp_rdata); end
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid === 1'b1) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt != 0) begin errors++; $display("FAIL midreset_rsp: got %0d responses expected 0", cnt); end
    do_req(1'b0, 1'b0, 32'h80, 64'h0, rd, er, lat);
    checks++; if (rd !== 64'h0BADF00D12345678) begin errors++; $display("FAIL midreset_mem: got %h expected 0badf00d12345678", rd); end
  endtask

  task automatic test_align;
    logic [63:0] rd, erd; logic er, eer; int lat;
    model(1'b0, 1'b1, 32'h42, 64'h0, erd, eer);
    do_req(1'b0, 1'b1, 32'h42, 64'h0, rd, er, lat);
    checks++; if (rd !== erd) begin errors++; $display("FAIL lw42_rdata: got %h expected %h", rd, erd); end
    checks++; if (er !== eer) begin errors++; $display("FAIL lw42_err: got %b expected %b", er, eer); end
    model(1'b1, 1'b0, 32'h44, 64'hFEEDFACE00C0FFEE, erd, eer);
    do_req(1'b1, 1'b0, 32'h44, 64'hFEEDFACE00C0FFEE, rd, er, lat);
    checks++; if (er !== eer || rd !== 64'h0) begin errors++; $display("FAIL sd44: err=%b rdata=%h expected err=%b rdata=0", er, rd, eer); end
    model(1'b0, 1'b0, 32'h40, 64'h0, erd, eer);
    do_req(1'b0, 1'b0, 32'h40, 64'h0, rd, er, lat);
    checks++; if (rd !== erd) begin errors++; $display("FAIL sd44_mem: got %h expected %h", rd, erd); end
  endtask

  task automatic test_random;
    logic [63:0] rd, erd, wd; logic er, eer; int lat;
    logic [31:0] addr; bit we, word;
    for (int i = 0; i < 32; i++) begin
      wd = {$urandom, $urandom};
      addr = 32'h100 + 32'(i * 8);
      model(1'b1, 1'b0, addr, wd, erd, eer);
      do_req(1'b1, 1'b0, addr, wd, rd, er, lat);
    end
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      word = 1'($urandom_range(0, 1));
      addr = 32'h100 + 32'($urandom_range(0, 255)) + (32'($urandom_range(0, 3)) << 13);
      wd   = {$urandom, $urandom};
      model(we, word, addr, wd, erd, eer);
      do_req(we, word, addr, wd, rd, er, lat);
      checks++;
      if (lat != LAT || rd !== erd || er !== eer) begin
        errors++;
        $display("FAIL rand_%0d: we=%b word=%b addr=%h lat=%0d rdata=%h err=%b expected lat=%0d rdata=%h err=%b",
                 i, we, word, addr, lat, rd, er, LAT, erd, eer);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dword_round_trip();
    test_word_half();
    test_busy_ignore();
    test_wrap();
    test_reset_mid();
    test_align();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
